// File: rtl/ram_arbiter_if.sv
// Client-side bus of the two-port RAM arbiter: per-requester valid/ready
// handshake, write payload, tagged read return and the init_done status.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16
);
    localparam int AW = $clog2(N_WORDS);

    logic                  req0;
    logic                  we0;
    logic [AW-1:0]         addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;

    logic                  req1;
    logic                  we1;
    logic [AW-1:0]         addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  init_done;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, init_done
    );

    // Client side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, init_done
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin front end sharing one synchronous single-port RAM between two
// requesters. Clears the RAM to INIT_VALUE after reset, then arbitrates with
// a combinational grant and returns reads two cycles after the handshake.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16,
    parameter int INIT_VALUE = 0,
    localparam int AW        = $clog2(N_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  ram_we_q, ram_we_d;
    logic [AW-1:0]         ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    // Read-return pipeline: bit 0 is the stage loaded at the handshake edge,
    // bit 1 is the stage whose contents line up with ram_data_out.
    logic [1:0]            rv_q, rv_d;
    logic [1:0]            tag_q, tag_d;

    logic                  run;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [1:0]            rvalid_vec;
    logic                  win;
    logic                  xfer;

    assign run = (state_q == ST_RUN);
    assign req = {bus.req1, bus.req0};

    // Grant: a lone requester always wins; on a tie the one not served last wins
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = run && req[0] && (!req[1] || last_q);
        gnt[1] = run && req[1] && (!req[0] || !last_q);
    end

    assign win  = gnt[1];
    assign xfer = |gnt;

    // One rvalid per requester, decoded from the tag in the last pipeline stage
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        assign rvalid_vec[gi] = rv_q[1] && (tag_q[1] == 1'(gi));
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.rvalid0   = rvalid_vec[0];
    assign bus.rvalid1   = rvalid_vec[1];
    assign bus.rdata     = ram_data_out;
    assign bus.init_done = run;

    assign ram_we      = ram_we_q;
    assign ram_address = ram_addr_q;
    assign ram_data_in = ram_din_q;

    // Next state: clear sweep in INIT, register the winning transfer in RUN
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rv_d       = {rv_q[0], 1'b0};
        tag_d      = {tag_q[0], 1'b0};

        if (state_q == ST_INIT) begin
            ram_we_d   = 1'b1;
            ram_addr_d = cnt_q;
            ram_din_d  = DATA_WIDTH'(INIT_VALUE);
            cnt_d      = cnt_q + AW'(1);
            if (cnt_q == AW'(N_WORDS - 1)) begin
                state_d = ST_RUN;
            end
        end else if (xfer) begin
            last_d     = win;
            ram_we_d   = win ? bus.we1 : bus.we0;
            ram_addr_d = win ? bus.addr1 : bus.addr0;
            ram_din_d  = win ? bus.wdata1 : bus.wdata0;
            if (!(win ? bus.we1 : bus.we0)) begin
                rv_d[0]  = 1'b1;
                tag_d[0] = win;
            end
        end
    end

    // State registers; reset also drops any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rv_q       <= 2'b00;
            tag_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rv_q       <= rv_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural synchronous RAM, gnt vector table,
// scoreboard of expected read returns, reset-mid-read and random soak.
module tb_ram_arbiter;
    localparam int DW = 8;
    localparam int NW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          scramble;

    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_WIDTH(DW), .N_WORDS(NW)) bus ();

    ram_arbiter #(.DATA_WIDTH(DW), .N_WORDS(NW), .INIT_VALUE(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_we       (ram_we),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Single-port RAM, synchronous write and read; scramble fills garbage
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < NW; i++) mem[i] <= 8'hF0 | 8'(i);
        end else begin
            if (ram_we) mem[ram_address] <= ram_data_in;
            ram_data_out <= mem[ram_address];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard of expected read returns plus a model of memory contents
    typedef struct {
        logic          tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] model [NW];

    always @(negedge clk) begin
        cyc++;
        if (bus.rvalid0 || bus.rvalid1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rvalid=%b%b expected none (cycle %0d)",
                         bus.rvalid1, bus.rvalid0, cyc);
            end else begin
                e = sb.pop_front();
                chk("rvalid_tag", {30'd0, bus.rvalid1, bus.rvalid0}, e.tag ? 32'd2 : 32'd1);
                chk("rdata", 32'(bus.rdata), 32'(e.data));
                chk("rvalid_cycle", cyc, e.due);
                $display("read return: port %0d data %02h (cycle %0d)", e.tag, bus.rdata, cyc);
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing: got none expected port %0d data %02h at cycle %0d",
                     sb[0].tag, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end
        chk("gnt_exclusive", {31'd0, bus.gnt0 && bus.gnt1}, 32'd0);
        chk("gnt_before_init", {31'd0, (bus.gnt0 || bus.gnt1) && !bus.init_done}, 32'd0);
        if (rst) begin
            sb.delete();
            for (int i = 0; i < NW; i++) model[i] = '0;
        end else begin
            if (bus.req0 && bus.gnt0) begin
                if (bus.we0) model[bus.addr0] = bus.wdata0;
                else sb.push_back('{tag: 1'b0, data: model[bus.addr0], due: cyc + 2});
            end
            if (bus.req1 && bus.gnt1) begin
                if (bus.we1) model[bus.addr1] = bus.wdata1;
                else sb.push_back('{tag: 1'b1, data: model[bus.addr1], due: cyc + 2});
            end
        end
    end

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic g0, g1;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic g0, logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic drive(vec_t v);
        bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic          pend [2];
    int            done [2];
    logic          sw [2];
    logic [AW-1:0] sa [2];
    logic [DW-1:0] sd [2];
    int            rv_seen;
    int            k;

    initial begin
        rst      = 1'b1;
        scramble = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        scramble = 1'b0;

        // Reset values while rst is held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_init_done", 32'(bus.init_done), 0);
            chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
            chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_ram_address", 32'(ram_address), 0);
            chk("rst_ram_data_in", 32'(ram_data_in), 0);
            $display("reset cycle %0d checked", i);
            next_cycle();
        end
        rst = 1'b0;

        // Clear sweep: cycles 0..15, req0 already waiting
        for (int c = 0; c < NW; c++) begin
            @(negedge clk);
            chk("init_done_low", 32'(bus.init_done), 0);
            chk("init_gnt0", 32'(bus.gnt0), 0);
            chk("init_ram_we", 32'(ram_we), (c >= 1) ? 1 : 0);
            if (c >= 1) begin
                chk("init_ram_address", 32'(ram_address), 32'(c - 1));
                chk("init_ram_data_in", 32'(ram_data_in), 0);
            end
            $display("init cycle %0d: we=%b addr=%0d", c, ram_we, ram_address);
            next_cycle();
        end

        // Vector table: readback of cleared RAM, single requester,
        // contention, cross-requester ordering
        for (int i = 0; i < NW; i++) tbl.push_back(mk(1, 0, AW'(i), 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5, 8'hA5, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 5, 0,     0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 5, 0,     1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 6, 0,     1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 6, 0,     1, 0, 7, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8, 0,     1, 0, 7, 0, 0, 1));
        tbl.push_back(mk(1, 0, 8, 0,     1, 0, 9, 0, 1, 0));
        tbl.push_back(mk(1, 0, 10, 0,    1, 0, 9, 0, 0, 1));
        tbl.push_back(mk(1, 0, 10, 0,    0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 1, 3, 8'h3C, 0, 1));
        tbl.push_back(mk(1, 0, 3, 0,     0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk("tbl_gnt0", 32'(bus.gnt0), 32'(tbl[i].g0));
            chk("tbl_gnt1", 32'(bus.gnt1), 32'(tbl[i].g1));
            if (i == 0) begin
                chk("init_done_rise", 32'(bus.init_done), 1);
                chk("last_sweep_we", 32'(ram_we), 1);
                chk("last_sweep_addr", 32'(ram_address), 15);
            end
            $display("vector %0d: gnt=%b%b", i, bus.gnt1, bus.gnt0);
            next_cycle();
        end

        // Reset one cycle after a read handshake: return must be dropped
        drive(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("midrst_gnt0", 32'(bus.gnt0), 1);
        next_cycle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst     = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rvalid0 || bus.rvalid1) rv_seen++;
            next_cycle();
        end
        rst = 1'b0;
        chk("midrst_no_rvalid", 32'(rv_seen), 0);
        $display("mid-read reset: rvalids seen %0d", rv_seen);
        next_cycle();
        @(negedge clk);
        chk("resweep_we", 32'(ram_we), 1);
        chk("resweep_addr", 32'(ram_address), 0);
        k = 0;
        while (!bus.init_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("reinit_done", 32'(bus.init_done), 1);
        next_cycle();
        drive(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("post_rst_gnt0", 32'(bus.gnt0), 1);
        next_cycle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (4) next_cycle();

        // Random soak: 100 requests per port, fields held until granted
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; done[p] = 0; sw[p] = 1'b0; sa[p] = '0; sd[p] = '0;
        end
        for (int cy = 0; cy < 3000 && (done[0] < 100 || done[1] < 100); cy++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && done[p] < 100 && $urandom_range(0, 3) != 0) begin
                    pend[p] = 1'b1;
                    sw[p]   = 1'($urandom_range(0, 1));
                    sa[p]   = AW'($urandom_range(0, NW - 1));
                    sd[p]   = DW'($urandom_range(0, 255));
                end
            end
            drive(mk(pend[0], sw[0], sa[0], sd[0], pend[1], sw[1], sa[1], sd[1], 0, 0));
            @(negedge clk);
            if (bus.req0 && bus.gnt0) begin pend[0] = 1'b0; done[0]++; end
            if (bus.req1 && bus.gnt1) begin pend[1] = 1'b0; done[1]++; end
            next_cycle();
        end
        chk("soak_transfers", 32'(done[0] + done[1]), 200);
        $display("soak: port0 %0d port1 %0d transfers", done[0], done[1]);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (5) next_cycle();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
